wt_ram_arbiter: RTL

- Shares one single-port wavetable RAM between NUM_VOICES wavetable oscillator read ports and one host table-load write port.
- Voice reads are arbitrated round-robin; host writes take priority, with a starvation guard for reads.
- Sits between the oscillator voices and the wavetable RAM instance.
- Each voice sees a simple req/ack read interface returning a registered data word.

---
 rtl/wt_ram_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wt_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wt_ram_arbiter: shares one single-port wavetable RAM between round-robin   |
// | voice reads and a priority host write port.         Revision 1.0          |
// +----------------------------------------------------------------------------+
module wt_ram_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int ADDRWIDTH  = 8,
  parameter int BANKWIDTH  = 2,
  parameter int DATAWIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_VOICES-1:0]           req,
  input  logic [NUM_VOICES*ADDRWIDTH-1:0] req_addr,
  input  logic [NUM_VOICES*BANKWIDTH-1:0] req_bank,
  output logic [NUM_VOICES-1:0]           ack,
  output logic [DATAWIDTH-1:0]            rdata_out,
  input  logic                            host_wr_req,
  input  logic [ADDRWIDTH-1:0]            host_wr_addr,
  input  logic [BANKWIDTH-1:0]            host_wr_bank,
  input  logic [DATAWIDTH-1:0]            host_wr_data,
  output logic                            host_wr_ack,
  output logic [ADDRWIDTH+BANKWIDTH-1:0]  ram_addr,
  output logic                            ram_re,
  output logic                            ram_we,
  output logic [DATAWIDTH-1:0]            ram_wdata,
  input  logic [DATAWIDTH-1:0]            ram_rdata
);

  localparam int VW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int RAW = ADDRWIDTH + BANKWIDTH;
  localparam logic [VW-1:0] C_LAST = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [VW-1:0]         rr, rr_nx;
  logic [VW-1:0]         gnt, gnt_nx;
  logic                  last_was_write, last_was_write_nx;

  logic [NUM_VOICES-1:0] ack_nx;
  logic [DATAWIDTH-1:0]  rdata_nx;
  logic                  host_wr_ack_nx;
  logic [RAW-1:0]        ram_addr_nx;
  logic                  ram_re_nx;
  logic                  ram_we_nx;
  logic [DATAWIDTH-1:0]  ram_wdata_nx;

  logic [NUM_VOICES-1:0] req_m;
  logic                  wr_m;
  logic                  any_rd;
  logic [VW-1:0]         pick;
  logic                  pick_hit;
  logic [ADDRWIDTH-1:0]  sel_addr;
  logic [BANKWIDTH-1:0]  sel_bank;
  logic [NUM_VOICES-1:0] gnt_onehot;
  int                    tgt;

  // A requester whose ack is high this cycle may still be holding its request.
  assign req_m  = req & ~ack;
  assign wr_m   = host_wr_req & ~host_wr_ack;
  assign any_rd = |req_m;

  // Round-robin search starting at rr, wrapping modulo NUM_VOICES.
  always_comb begin
    pick     = rr;
    pick_hit = 1'b0;
    tgt      = 0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      tgt = int'(rr) + k;
      if (tgt >= NUM_VOICES) tgt = tgt - NUM_VOICES;
      for (int j = 0; j < NUM_VOICES; j++) begin
        if (!pick_hit && req_m[j] && (tgt == j)) begin
          pick_hit = 1'b1;
          pick     = VW'(j);
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_bank = '0;
    for (int j = 0; j < NUM_VOICES; j++) begin
      if (pick == VW'(j)) begin
        sel_addr = req_addr[j*ADDRWIDTH +: ADDRWIDTH];
        sel_bank = req_bank[j*BANKWIDTH +: BANKWIDTH];
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    for (int j = 0; j < NUM_VOICES; j++) begin
      gnt_onehot[j] = (gnt == VW'(j));
    end
  end

  always_comb begin
    state_nx          = state;
    rr_nx             = rr;
    gnt_nx            = gnt;
    last_was_write_nx = last_was_write;
    ack_nx            = '0;
    rdata_nx          = rdata_out;
    host_wr_ack_nx    = 1'b0;
    ram_addr_nx       = ram_addr;
    ram_re_nx         = 1'b0;
    ram_we_nx         = 1'b0;
    ram_wdata_nx      = ram_wdata;
    case (state)
      IDLE: begin
        // Writes win unless the previous grant was also a write and reads wait.
        if (wr_m && !(last_was_write && any_rd)) begin
          ram_addr_nx       = {host_wr_bank, host_wr_addr};
          ram_wdata_nx      = host_wr_data;
          ram_we_nx         = 1'b1;
          last_was_write_nx = 1'b1;
          state_nx          = WR;
        end else if (any_rd) begin
          ram_addr_nx       = {sel_bank, sel_addr};
          ram_re_nx         = 1'b1;
          gnt_nx            = pick;
          rr_nx             = (pick == C_LAST) ? '0 : pick + VW'(1);
          last_was_write_nx = 1'b0;
          state_nx          = RD;
        end
      end
      RD: begin
        state_nx = CAP;
      end
      CAP: begin
        rdata_nx = ram_rdata;
        ack_nx   = gnt_onehot;
        state_nx = IDLE;
      end
      WR: begin
        host_wr_ack_nx = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr             <= '0;
      gnt            <= '0;
      last_was_write <= 1'b0;
      ack            <= '0;
      rdata_out      <= '0;
      host_wr_ack    <= 1'b0;
      ram_addr       <= '0;
      ram_re         <= 1'b0;
      ram_we         <= 1'b0;
      ram_wdata      <= '0;
    end else begin
      state          <= state_nx;
      rr             <= rr_nx;
      gnt            <= gnt_nx;
      last_was_write <= last_was_write_nx;
      ack            <= ack_nx;
      rdata_out      <= rdata_nx;
      host_wr_ack    <= host_wr_ack_nx;
      ram_addr       <= ram_addr_nx;
      ram_re         <= ram_re_nx;
      ram_we         <= ram_we_nx;
      ram_wdata      <= ram_wdata_nx;
    end
  end

endmodule
`default_nettype wire
